// File: rtl/sd_emmc_pkg.sv
// Shared definitions for the SD/eMMC AXI write arbiter: FSM states,
// AXI response codes and requester indices.
package sd_emmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Requester 0 is the SDMA engine, requester 1 the status/descriptor writeback.
  localparam int REQ_SDMA = 0;
  localparam int REQ_WB   = 1;

endpackage

// File: rtl/sd_emmc_rr_arbiter2.sv
// Two-way combinational grant decision. Round-robin on ties; strict priority
// to requester 0 when SD_EMMC_ARB_FIXED_PRIO_EN is defined.
module sd_emmc_rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,   // index of the requester served last
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0] && i_req[1]) begin
`ifdef SD_EMMC_ARB_FIXED_PRIO_EN
      o_gnt = 2'b01;
`else
      o_gnt = i_last ? 2'b01 : 2'b10;
`endif
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/sd_emmc_axi_wr_arbiter.sv
// Arbitrates two single-word write requesters onto one AXI write master,
// one outstanding transaction. Optional macro: SD_EMMC_ARB_FIXED_PRIO_EN.
module sd_emmc_axi_wr_arbiter
  import sd_emmc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_done,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_done,
  output logic              req1_err,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wvalid,
  output logic              m_wlast,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready
);

  arb_state_e        r_state;
  logic [1:0]        r_grant;
  logic              r_last;
  logic [ADDR_W-1:0] r_awaddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic [1:0]        r_done;
  logic [1:0]        r_err;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_aw_done;
  logic              w_w_done;

  assign w_req = {req1_valid, req0_valid};

  sd_emmc_rr_arbiter2 u_arb (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign w_sel_addr = w_gnt[REQ_WB] ? req1_addr : req0_addr;
  assign w_sel_data = w_gnt[REQ_WB] ? req1_data : req0_data;

  // A channel counts as done once its handshake happened earlier or happens now.
  assign w_aw_hs   = r_awvalid & m_awready;
  assign w_w_hs    = r_wvalid & m_wready;
  assign w_aw_done = ~r_awvalid | w_aw_hs;
  assign w_w_done  = ~r_wvalid | w_w_hs;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 2'b00;
      r_err     <= 2'b00;
    end else begin
      r_done <= 2'b00;
      r_err  <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant   <= w_gnt;
            r_awaddr  <= w_sel_addr & ~ADDR_W'(3);
            r_wdata   <= w_sel_data;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_last    <= w_gnt[REQ_WB];
            r_state   <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_bvalid) begin
            r_done   <= r_grant;
            r_err    <= (m_bresp != AXI_RESP_OKAY) ? r_grant : 2'b00;
            r_grant  <= 2'b00;
            r_bready <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign m_awaddr  = r_awaddr;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wvalid  = r_wvalid;
  assign m_wlast   = r_wvalid;
  assign m_bready  = r_bready;
  assign req0_done = r_done[REQ_SDMA];
  assign req1_done = r_done[REQ_WB];
  assign req0_err  = r_err[REQ_SDMA];
  assign req1_err  = r_err[REQ_WB];

endmodule

// File: doc/sd_emmc_axi_wr_arbiter.md
SD_EMMC_AXI_WR_ARBITER -- requirements
Module: sd_emmc_axi_wr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI write address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI write data width.
REQ-003 SHALL have port clock  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports reqN_valid  in  1  write request from requester N (N=0 SDMA engine, N=1 status/descriptor writeback).
REQ-006 SHALL have ports reqN_addr  in  ADDR_W  and  reqN_data  in  DATA_W  byte address and word for requester N.
REQ-007 SHALL have ports reqN_done  out  1  one-cycle completion pulse for requester N.
REQ-008 SHALL have ports reqN_err  out  1  qualifies reqN_done; high when the response is not OKAY.
REQ-009 SHALL have port grant  out  2  one-hot owner; 2'b00 when idle.
REQ-010 SHALL have ports m_awaddr out ADDR_W, m_awvalid out 1, m_awready in 1: AXI write-address channel.
REQ-011 SHALL have ports m_wdata out DATA_W, m_wvalid out 1, m_wlast out 1, m_wready in 1: AXI write-data channel.
REQ-012 SHALL have ports m_bvalid in 1, m_bresp in 2, m_bready out 1: AXI write-response channel.

Function
REQ-013 SHALL implement states IDLE, XFER, RESP, with at most one transaction outstanding.
REQ-014 IDLE: when any reqN_valid is high, SHALL register the winner into grant, m_awaddr and m_wdata, assert m_awvalid and m_wvalid, and enter XFER on the next edge (1-cycle grant latency).
REQ-015 Arbitration SHALL be round-robin: on simultaneous requests, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-016 XFER: SHALL drop m_awvalid on the cycle after the m_awvalid&m_awready handshake and drop m_wvalid on the cycle after the m_wvalid&m_wready handshake. The two channels complete independently in either order or in the same cycle.
REQ-017 m_awvalid and m_wvalid SHALL NOT deassert, and m_awaddr and m_wdata SHALL NOT change, until their respective handshakes occur.
REQ-018 m_wlast SHALL equal m_wvalid (single-beat bursts only).
REQ-019 SHALL enter RESP once both handshakes are done, and assert m_bready only in RESP.
REQ-020 RESP: on m_bvalid, SHALL pulse reqN_done for the granted N, set reqN_err = (m_bresp != 2'b00), clear grant, and return to IDLE.
REQ-021 A new grant SHALL be possible on the cycle after done (back-to-back throughput: 1 transaction per 3 cycles minimum with zero-wait slave).
REQ-022 reqN_addr and reqN_data SHALL be sampled only at grant; the requester holds reqN_valid until reqN_done.
REQ-023 Deassertion of reqN_valid by the granted requester mid-transaction SHALL be ignored; the transaction completes.
REQ-024 m_bvalid outside RESP SHALL be ignored.
REQ-025 m_awaddr bits [1:0] SHALL be forced to 2'b00 (word aligned).

Reset
REQ-026 Reset SHALL force state IDLE; grant=0; m_awvalid, m_wvalid, m_wlast, m_bready, reqN_done, reqN_err = 0; m_awaddr and m_wdata = 0; round-robin pointer to "last served = 1".
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction without a done pulse; outputs reach reset values on the next edge.

Configuration
REQ-028 Macro SD_EMMC_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win simultaneous requests (strict priority).
REQ-029 Macro SD_EMMC_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.

Structure
REQ-030 The state encoding, the AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the requester index constants SHALL live in the shared package sd_emmc_pkg.
REQ-031 The grant decision SHALL be a sub-module sd_emmc_rr_arbiter2 (2 requests plus last-served pointer in, one-hot grant out, combinational), instantiated once.

Verification
REQ-032 Only req0, addr 0x1000_0004, data 0xDEADBEEF, ready always 1, bresp 0 -> grant=01, AW/W beat with wlast=1, req0_done after 3 cycles, req0_err=0.
REQ-033 req0 and req1 held continuously -> grants alternate 01,10,01,10 (macro off); with macro on -> all grants 01.
REQ-034 m_awready delayed 4 cycles, m_wready immediate -> wvalid drops first, awaddr stable until accept, done after bvalid.
REQ-035 bresp=2'b10 on req1 -> req1_done=1 with req1_err=1, req0_done stays 0.
REQ-036 reset pulsed during XFER -> next cycle all outputs 0, no done pulse; the following request is granted normally.
REQ-037 req1_addr=0x2003 -> m_awaddr=0x2000.
